// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU op sequencer: opcodes, FSM encoding, PSR flag bit positions.
package alu_seq_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_OPND = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;

  // psr_flags = {C, L, F, Z, N}
  localparam int unsigned FLG_C = 4;
  localparam int unsigned FLG_L = 3;
  localparam int unsigned FLG_F = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_N = 0;

  function automatic logic is_legal_op(input logic [7:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC, OP_RSH,
      OP_SUB, OP_SUBC, OP_CMP, OP_ALSH, OP_MUL, OP_ARSH, OP_LSH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction, register-file and ALU signals of the sequencer. master = sequencer view,
// slave = decode/RF/ALU view. Optional immediate operand ports under ALU_SEQ_IMM_EN.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OPC_W  = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
`ifdef ALU_SEQ_IMM_EN
  logic              instr_use_imm;
  logic [DATA_W-1:0] instr_imm;
`endif
  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_r1;
  logic [DATA_W-1:0] alu_r2;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_rout;
  logic [4:0]        psr_flags;
  logic              done;
  logic              illegal_op;

  modport master (
`ifdef ALU_SEQ_IMM_EN
    input  instr_use_imm, instr_imm,
`endif
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_rout,
    output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    output alu_r1, alu_r2, alu_opcode, psr_flags, done, illegal_op
  );

  modport slave (
`ifdef ALU_SEQ_IMM_EN
    output instr_use_imm, instr_imm,
`endif
    output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_rout,
    input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    input  alu_r1, alu_r2, alu_opcode, psr_flags, done, illegal_op
  );
endinterface

// File: rtl/alu_seq_flags.sv
// Combinational PSR update from ALU operands, result and opcode; unnamed flags hold.
module alu_seq_flags
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] rout,
  input  logic [7:0]        opcode,
  input  logic [4:0]        flags_old,
  output logic [4:0]        flags_new
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, r1} + {1'b0, r2};
  assign diff = {1'b0, r1} - {1'b0, r2};

  always_comb begin
    flags_new        = flags_old;
    flags_new[FLG_Z] = (rout == '0);
    case (opcode)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        flags_new[FLG_C] = sum[DATA_W];
        flags_new[FLG_F] = (r1[MSB] == r2[MSB]) && (sum[MSB] != r1[MSB]);
      end
      OP_SUB, OP_SUBC: begin
        // Top bit of the 17-bit difference is the borrow, i.e. r1 < r2 unsigned.
        flags_new[FLG_C] = diff[DATA_W];
        flags_new[FLG_F] = (r1[MSB] != r2[MSB]) && (diff[MSB] != r1[MSB]);
      end
      OP_CMP: begin
        flags_new[FLG_Z] = (r1 == r2);
        flags_new[FLG_L] = (r1 < r2);
        flags_new[FLG_N] = ($signed(r1) < $signed(r2));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU instruction: RF read, operand register, execute/flags, write-back.
// Optional ALU_SEQ_IMM_EN replaces operand 2 with a latched immediate.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OPC_W  = 8
) (
  input logic           clock,
  input logic           reset,
  alu_op_sequencer_if.master bus
);

  logic [2:0]        state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, wdata_q, wdata_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [4:0]        flags_q, flags_d, flags_new;
  logic              illegal_q, illegal_d;
`ifdef ALU_SEQ_IMM_EN
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q, imm_d;
`endif

  alu_seq_flags #(.DATA_W(DATA_W)) u_flags (
    .r1        (r1_q),
    .r2        (r2_q),
    .rout      (bus.alu_rout),
    .opcode    (opc_q),
    .flags_old (flags_q),
    .flags_new (flags_new)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    opc_d     = opc_q;
    wdata_d   = wdata_q;
    flags_d   = flags_q;
    illegal_d = 1'b0;
`ifdef ALU_SEQ_IMM_EN
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          // Illegal opcodes are consumed in place: no latch, no RF access.
          if (is_legal_op(bus.instr[15:8])) begin
            state_d = ST_READ;
            instr_d = bus.instr;
`ifdef ALU_SEQ_IMM_EN
            use_imm_d = bus.instr_use_imm;
            imm_d     = bus.instr_imm;
`endif
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_READ: state_d = ST_OPND;
      ST_OPND: begin
        state_d = ST_EXEC;
        r1_d    = bus.rf_rdata_a;
`ifdef ALU_SEQ_IMM_EN
        r2_d    = use_imm_q ? imm_q : bus.rf_rdata_b;
`else
        r2_d    = bus.rf_rdata_b;
`endif
        opc_d   = instr_q[8 +: OPC_W];
      end
      ST_EXEC: begin
        state_d = ST_WB;
        wdata_d = bus.alu_rout;
        flags_d = flags_new;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      opc_q     <= '0;
      wdata_q   <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_SEQ_IMM_EN
      use_imm_q <= 1'b0;
      imm_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      opc_q     <= opc_d;
      wdata_q   <= wdata_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
`ifdef ALU_SEQ_IMM_EN
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
`endif
    end
  end

  always_comb begin
    bus.instr_ready = (state_q == ST_IDLE);
    bus.rf_raddr_a  = instr_q[4 +: REG_AW];
    bus.rf_raddr_b  = instr_q[0 +: REG_AW];
    bus.rf_waddr    = instr_q[4 +: REG_AW];
    bus.rf_wdata    = wdata_q;
    bus.done        = (state_q == ST_WB);
    bus.rf_we       = (state_q == ST_WB) && (opc_q != OP_CMP);
    bus.alu_r1      = r1_q;
    bus.alu_r2      = r2_q;
    bus.alu_opcode  = opc_q;
    bus.psr_flags   = flags_q;
    bus.illegal_op  = illegal_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed instructions, RF and ALU models, queue-based monitor.
module tb_alu_op_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_op_sequencer_if #(.DATA_W(16), .REG_AW(4), .OPC_W(8)) bus ();

  alu_op_sequencer #(.DATA_W(16), .REG_AW(4), .OPC_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rf [16];

  always @(posedge clock) begin
    bus.rf_rdata_a <= rf[bus.rf_raddr_a];
    bus.rf_rdata_b <= rf[bus.rf_raddr_b];
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  always_comb begin
    case (bus.alu_opcode)
      8'h01:               bus.alu_rout = bus.alu_r1 & bus.alu_r2;
      8'h02:               bus.alu_rout = bus.alu_r1 | bus.alu_r2;
      8'h03:               bus.alu_rout = bus.alu_r1 ^ bus.alu_r2;
      8'h04:               bus.alu_rout = ~bus.alu_r1;
      8'h05, 8'h06, 8'h07: bus.alu_rout = bus.alu_r1 + bus.alu_r2;
      8'h09, 8'h0A, 8'h0B: bus.alu_rout = bus.alu_r1 - bus.alu_r2;
      default:             bus.alu_rout = 16'h0000;
    endcase
  end

  typedef struct {
    logic        ill;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [4:0]  flags;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [7:0]  opc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void exp_op(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                                 input logic [4:0] fl, input logic [15:0] r1,
                                 input logic [15:0] r2, input logic [7:0] opc);
    exp_t e;
    e.ill = 1'b0; e.we = we; e.waddr = wa; e.wdata = wd; e.flags = fl;
    e.r1 = r1; e.r2 = r2; e.opc = opc; e.lat = 4;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_ill(input logic [4:0] fl);
    exp_t e;
    e.ill = 1'b1; e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.flags = fl;
    e.r1 = '0; e.r2 = '0; e.opc = '0; e.lat = 1;
    exp_q.push_back(e);
  endfunction

  // Monitor: every done or illegal_op pulse consumes one expected entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.rf_we && !bus.done) chk("rf_we_outside_wb", 32'(bus.rf_we), 32'd0);
      if (bus.done || bus.illegal_op) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bus.done, bus.illegal_op}, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          chk("kind_illegal", 32'(bus.illegal_op), 32'(e.ill));
          chk("latency", 32'(cyc - a), 32'(e.lat));
          chk("flags", 32'(bus.psr_flags), 32'(e.flags));
          chk("rf_we", 32'(bus.rf_we), 32'(e.we));
          if (e.ill) begin
            chk("ready_on_illegal", 32'(bus.instr_ready), 32'd1);
          end else begin
            chk("waddr", 32'(bus.rf_waddr), 32'(e.waddr));
            chk("alu_r1", 32'(bus.alu_r1), 32'(e.r1));
            chk("alu_r2", 32'(bus.alu_r2), 32'(e.r2));
            chk("alu_opcode", 32'(bus.alu_opcode), 32'(e.opc));
            if (e.we) chk("wdata", 32'(bus.rf_wdata), 32'(e.wdata));
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ins, output int acc);
    int n;
    n = 0;
    @(negedge clock);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.instr_ready) begin
      chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      acc_q.push_back(cyc);
      @(posedge clock);
    end
  endtask

  task automatic release_valid();
    @(negedge clock);
    bus.instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal_op), 32'd0);
    chk({tag, "_r1"}, 32'(bus.alu_r1), 32'd0);
    chk({tag, "_r2"}, 32'(bus.alu_r2), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.rf_wdata), 32'd0);
    chk({tag, "_opcode"}, 32'(bus.alu_opcode), 32'd0);
    chk({tag, "_flags"}, 32'(bus.psr_flags), 32'd0);
    chk({tag, "_raddr_a"}, 32'(bus.rf_raddr_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
`ifdef ALU_SEQ_IMM_EN
    bus.instr_use_imm = 1'b0;
    bus.instr_imm = 16'h0000;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 32'(bus.instr_ready), 32'd1);

    // ADD 1+1
    rf[1] = 16'h0001; rf[2] = 16'h0001;
    exp_op(1'b1, 4'd1, 16'h0002, 5'b00000, 16'h0001, 16'h0001, 8'h05);
    issue(16'h0512, a1); release_valid(); drain();
    // ADD FFFF+1: C, Z
    rf[3] = 16'hFFFF; rf[4] = 16'h0001;
    exp_op(1'b1, 4'd3, 16'h0000, 5'b10010, 16'hFFFF, 16'h0001, 8'h05);
    issue(16'h0534, a1); release_valid(); drain();
    // ADD 7FFF+1: signed overflow
    rf[5] = 16'h7FFF; rf[6] = 16'h0001;
    exp_op(1'b1, 4'd5, 16'h8000, 5'b00100, 16'h7FFF, 16'h0001, 8'h05);
    issue(16'h0556, a1); release_valid(); drain();
    // SUB 1-2: borrow
    rf[7] = 16'h0001; rf[8] = 16'h0002;
    exp_op(1'b1, 4'd7, 16'hFFFF, 5'b10000, 16'h0001, 16'h0002, 8'h09);
    issue(16'h0978, a1); release_valid(); drain();
    // CMP FFFF vs 2: no write, N=1, L=0, C held
    rf[9] = 16'hFFFF; rf[10] = 16'h0002;
    exp_op(1'b0, 4'd9, 16'h0000, 5'b10001, 16'hFFFF, 16'h0002, 8'h0B);
    issue(16'h0B9A, a1); release_valid(); drain();
    chk("cmp_no_write", 32'(rf[9]), 32'h0000FFFF);
    // Illegal opcode 0D: flags unchanged
    exp_ill(5'b10001);
    issue(16'h0D12, a1); release_valid(); drain();
    // AND to zero: only Z changes
    rf[11] = 16'hF0F0; rf[12] = 16'h0F0F;
    exp_op(1'b1, 4'd11, 16'h0000, 5'b10011, 16'hF0F0, 16'h0F0F, 8'h01);
    issue(16'h01BC, a1); release_valid(); drain();
    // OR with Rdest == Rsrc
    rf[13] = 16'h1234;
    exp_op(1'b1, 4'd13, 16'h1234, 5'b10001, 16'h1234, 16'h1234, 8'h02);
    issue(16'h02DD, a1); release_valid(); drain();
    // Back-to-back with valid held; ADDU reads the XOR result just written
    rf[14] = 16'h00FF; rf[15] = 16'h0F0F;
    exp_op(1'b1, 4'd14, 16'h0FF0, 5'b10001, 16'h00FF, 16'h0F0F, 8'h03);
    exp_op(1'b1, 4'd14, 16'h1EFF, 5'b00001, 16'h0FF0, 16'h0F0F, 8'h06);
    issue(16'h03EF, a1);
    issue(16'h06EF, a2);
    release_valid(); drain();
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd5);
    chk("rf14_final", 32'(rf[14]), 32'h00001EFF);

    // Reset asserted in EXEC: abort, no write, outputs to reset values
    rf[3] = 16'h0001; rf[4] = 16'h0001;
    issue(16'h0534, a1);
    @(negedge clock); bus.instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    chk("mid_reset_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    acc_q.delete();
    repeat (6) @(negedge clock);
    chk("abort_no_write", 32'(rf[3]), 32'h00000001);

    // Normal op after abort
    rf[1] = 16'h0003; rf[2] = 16'h0004;
    exp_op(1'b1, 4'd1, 16'h0007, 5'b00000, 16'h0003, 16'h0004, 8'h05);
    issue(16'h0512, a1); release_valid(); drain();

`ifdef ALU_SEQ_IMM_EN
    rf[1] = 16'h0001; rf[0] = 16'h5555;
    bus.instr_use_imm = 1'b1;
    bus.instr_imm = 16'h00F0;
    exp_op(1'b1, 4'd1, 16'h00F1, 5'b00000, 16'h0001, 16'h00F0, 8'h02);
    issue(16'h0210, a1); release_valid();
    bus.instr_use_imm = 1'b0;
    bus.instr_imm = 16'h0000;
    drain();
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
